pipeline_ifp_stage: RTL
=======================

# pipeline_ifp_stage

Instruction Fetch Prepare stage: owns the program counter, chooses the ROM or DRAM fetch channel, and drives the instruction-memory address. It sits directly upstream of `pipeline_ifr_stage2`, feeding it `pc_IFP` and `if_channel_sel`. It runs a two-state DRAM read handshake that holds the PC until the word is delivered. A watchdog counter flags DRAM fetches that never complete.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `DRAM_BASE`, default 64'h8000_0000: PCs ≥ this value fetch from DRAM; lower PCs fetch from ROM.
- `TIMEOUT`, default 255: maximum cycles in WAIT before `fetch_fault` is raised (8-bit counter).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `stall`  in  1: hazard-unit stall; holds the PC.
- `redirect_valid`  in  1: branch/jump/trap redirect request.
- `redirect_pc`  in  64: redirect target.
- `dram_data_ready`  in  1: DRAM/cache read data valid.
- `pc_IFP`  out  64: current fetch PC.
- `if_channel_sel`  out  1: 1 = DRAM channel, 0 = ROM.
- `rom_addr`  out  64: ROM byte address, equal to `pc_IFP`; combinational ROM read.
- `dram_rd_en`  out  1: DRAM read request (level).
- `dram_addr`  out  64: DRAM byte address, equal to `pc_IFP`.
- `fetch_fault`  out  1: sticky DRAM fetch timeout flag.

## Operation
- `pc` register. `if_channel_sel` = (`pc` ≥ `DRAM_BASE`), unsigned, combinational.
- Redirect target is loaded with bits [1:0] forced to 0.
- Increment is `pc + 4`, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- FSM states:
  - **IDLE**: `dram_rd_en` = 0.
  - **WAIT**: `dram_rd_en` = 1, `dram_addr` = `pc`.
- Next-PC priority, highest first:
  1. `redirect_valid` → `pc` ← `redirect_pc` & ~3, state ← IDLE, wait counter cleared, `fetch_fault` cleared. Applies regardless of `stall` or state; an in-flight DRAM request is abandoned.
  2. `stall` → `pc` and state hold. The wait counter keeps counting in WAIT.
  3. ROM channel (IDLE, `if_channel_sel` = 0) → `pc` ← `pc + 4` every cycle.
  4. DRAM channel, IDLE → state ← WAIT, `pc` held.
  5. WAIT with `dram_data_ready` = 1 → `pc` ← `pc + 4`, state ← IDLE, counter ← 0.
  6. WAIT with `dram_data_ready` = 0 → hold; counter increments, saturating at 255.
- `fetch_fault` sets when the counter reaches `TIMEOUT` in WAIT. It stays set until a redirect or reset. The stage stays in WAIT; recovery is by redirect only.
- `dram_data_ready` is ignored in IDLE.
- Memory-side contract: while `dram_rd_en` = 1 and `dram_addr` is unchanged, `dram_data_ready`/`dram_dout` stay asserted once valid. This makes a stalled completion safe.
- Completion is the single edge where state is WAIT, `dram_data_ready` = 1, `stall` = 0, and `redirect_valid` = 0.

## Timing
- Reset (async) values: `pc` = `RESET_PC`, state IDLE, `dram_rd_en` = 0, counter = 0, `fetch_fault` = 0.
- All outputs derive from registers or from `pc` alone; there are no input-to-output combinational paths.
- ROM throughput: 1 PC per cycle. Downstream captures `rom_dout` for `pc_IFP` at the next edge.
- DRAM latency: minimum 2 cycles per instruction (IDLE + WAIT with ready in the same cycle). It is 1 + N cycles for ready after N WAIT cycles.
- Downstream sees bubbles (Instruction = 0) for every non-completing DRAM cycle.
- Redirect takes effect at the next edge: `pc_IFP` = target one cycle after `redirect_valid` is sampled.
- Redirect into the DRAM region spends one IDLE cycle before WAIT.
- Redirect and completion on the same edge: redirect wins, and the completed word is discarded downstream by the pipeline flush.
- `stall` and `dram_data_ready` on the same edge: no completion. Completion happens on the first unstalled edge with ready still high.
- `fetch_fault` rises on the edge the counter reaches `TIMEOUT`; it is visible the following cycle.

## Test plan
- **Reset/ROM**: assert reset mid-run with `RESET_PC` = 0, then release → `pc_IFP` sequence 0, 4, 8, 12; `if_channel_sel` = 0; `dram_rd_en` stays 0.
- **DRAM fetch**: redirect to 64'h8000_0000, ready 3 cycles into WAIT → one IDLE cycle, then `dram_rd_en` high for 3 cycles. `pc_IFP` becomes 64'h8000_0004 after the ready edge, and `dram_rd_en` drops for one cycle.
- **Stall at completion**: in WAIT, hold ready = 1 and stall = 1 for 2 cycles → PC holds 64'h8000_0000 and `dram_rd_en` stays 1. Advances to 64'h8000_0004 on the first unstalled edge.
- **Redirect priority**: `redirect_valid` with target 64'h0000_0102 while stall = 1 and in WAIT → next `pc_IFP` = 64'h100, state IDLE, `dram_rd_en` = 0.
- **Timeout**: `TIMEOUT` = 4, DRAM fetch with ready never asserted → `fetch_fault` = 1 after the 4th WAIT edge. It clears on redirect to 64'h0.
- **Wrap**: redirect to 64'hFFFF_FFFF_FFFF_FFFC with ready tied high → completion, then `pc_IFP` = 0 with `if_channel_sel` = 0.

Source files
------------

// File: rtl/pipeline_ifp_stage.sv
// Instruction Fetch Prepare stage: owns the PC, selects the ROM or DRAM fetch
// channel, and runs a two-state DRAM read handshake with a timeout watchdog.
module pipeline_ifp_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] DRAM_BASE = 64'h8000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        dram_data_ready,
  output logic [63:0] pc_IFP,
  output logic        if_channel_sel,
  output logic [63:0] rom_addr,
  output logic        dram_rd_en,
  output logic [63:0] dram_addr,
  output logic        fetch_fault
);

  // DRAM handshake: dram_rd_en is a level request held for the whole WAIT
  // state with dram_addr stable; a word is consumed on the single edge where
  // the stage is in WAIT, dram_data_ready=1, stall=0 and redirect_valid=0.
  // The memory keeps dram_data_ready high once valid while the request holds.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        dram_sel;
  logic [63:0] pc_inc;
  logic [7:0]  cnt_inc;

  assign dram_sel = (pc_q >= DRAM_BASE);
  assign pc_inc   = pc_q + 64'd4;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~64'd3;
      state_d = IDLE;
      cnt_d   = 8'd0;
      fault_d = 1'b0;
    end else if (stall) begin
      // A stalled WAIT still ages toward the timeout, even with data ready.
      if (state_q == WAIT) begin
        cnt_d   = cnt_inc;
        fault_d = fault_q | (cnt_inc == TIMEOUT_CNT);
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (dram_sel) begin
            state_d = WAIT;
            cnt_d   = 8'd0;
          end else begin
            pc_d = pc_inc;
          end
        end
        WAIT: begin
          if (dram_data_ready) begin
            pc_d    = pc_inc;
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d   = cnt_inc;
            fault_d = fault_q | (cnt_inc == TIMEOUT_CNT);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pc_IFP         = pc_q;
    rom_addr       = pc_q;
    dram_addr      = pc_q;
    if_channel_sel = dram_sel;
    dram_rd_en     = (state_q == WAIT);
    fetch_fault    = fault_q;
  end

endmodule
